// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the PS/2 lines,
// then decodes start/8 data/odd parity/stop frames into single-cycle byte or error pulses.
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall;

  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_acc_q;
  logic          par_bit_q;
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // fcnt_q counts consecutive samples that disagree with the current filtered level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_s2 == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q <= clk_s2;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~clk_s2 & (fcnt_q == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= StIdle;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      par_acc_q        <= 1'b0;
      par_bit_q        <= 1'b0;
      tmo_q            <= '0;
      received_data    <= '0;
      received_data_en <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;

      if (state_q == StIdle || fall) begin
        tmo_q <= '0;
      end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
        tmo_q <= tmo_q + 1'b1;
      end

      // A fall arriving in the expiry cycle wins over the timeout.
      if (state_q != StIdle && !fall && tmo_q == TW'(TIMEOUT_CYCLES)) begin
        frame_err <= 1'b1;
        state_q   <= StIdle;
      end else if (fall) begin
        unique case (state_q)
          StIdle: begin
            if (!dat_s2) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
              par_acc_q <= 1'b0;
            end
          end
          StData: begin
            shift_q   <= {dat_s2, shift_q[7:1]};
            par_acc_q <= par_acc_q ^ dat_s2;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            par_bit_q <= dat_s2;
            state_q   <= StStop;
          end
          StStop: begin
            if (!dat_s2) begin
              frame_err <= 1'b1;
            end else if (!(par_acc_q ^ par_bit_q)) begin
              parity_err <= 1'b1;
            end else begin
              received_data    <= shift_q;
              received_data_en <= 1'b1;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: clean frames, parity/stop/timeout errors,
// clock glitch rejection and mid-frame reset.
module tb_ps2_frame_receiver;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 400;
  localparam int unsigned HALF = 40;  // ps2_clk half period in system clocks

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_err;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;

  int en_cnt = 0, perr_cnt = 0, ferr_cnt = 0, multi_cnt = 0, wide_cnt = 0;
  logic en_p = 1'b0, perr_p = 1'b0, ferr_p = 1'b0;
  int en0, perr0, ferr0;

  ps2_frame_receiver #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ps2_clk         (ps2_clk),
    .ps2_dat         (ps2_dat),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .parity_err      (parity_err),
    .frame_err       (frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    en_cnt   <= en_cnt + int'(received_data_en);
    perr_cnt <= perr_cnt + int'(parity_err);
    ferr_cnt <= ferr_cnt + int'(frame_err);
    if (int'(received_data_en) + int'(parity_err) + int'(frame_err) > 1) multi_cnt <= multi_cnt + 1;
    if ((received_data_en && en_p) || (parity_err && perr_p) || (frame_err && ferr_p))
      wide_cnt <= wide_cnt + 1;
    en_p   <= received_data_en;
    perr_p <= parity_err;
    ferr_p <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_clk(HALF / 2);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
    wait_clk(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    ps2_dat = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic snap();
    en0 = en_cnt;
    perr0 = perr_cnt;
    ferr0 = ferr_cnt;
  endtask

  task automatic check_pulses(input string tag, input int e, input int p, input int f);
    check({tag, "_en"}, 32'(en_cnt - en0), 32'(e));
    check({tag, "_perr"}, 32'(perr_cnt - perr0), 32'(p));
    check({tag, "_ferr"}, 32'(ferr_cnt - ferr0), 32'(f));
  endtask

  initial begin
    wait_clk(5);
    check("rst_data", 32'(received_data), 32'h00);
    check("rst_pulses", {29'd0, received_data_en, parity_err, frame_err}, 32'd0);
    resetn = 1'b1;
    wait_clk(20);

    snap();
    send_frame(8'h1D, 1'b1, 1'b1);
    check_pulses("f1D", 1, 0, 0);
    check("f1D_data", 32'(received_data), 32'h1D);

    snap();
    send_frame(8'hF0, 1'b1, 1'b1);
    check("fF0_data", 32'(received_data), 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_pulses("b2b", 2, 0, 0);
    check("f1C_data", 32'(received_data), 32'h1C);

    snap();
    send_frame(8'h29, 1'b1, 1'b1);
    check_pulses("par29", 0, 1, 0);
    check("par29_data", 32'(received_data), 32'h1C);

    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    check_pulses("stop5A", 0, 0, 1);
    check("stop5A_data", 32'(received_data), 32'h1C);

    // Start bit plus four data bits, then silence beyond the timeout.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_clk(TMO + 100);
    check_pulses("tmo", 0, 0, 1);
    snap();
    send_frame(8'h76, 1'b0, 1'b1);
    check_pulses("f76", 1, 0, 0);
    check("f76_data", 32'(received_data), 32'h76);

    // A short low glitch with data low must not look like a start bit.
    snap();
    ps2_dat = 1'b0;
    wait_clk(5);
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(30);
    ps2_dat = 1'b1;
    wait_clk(10);
    check_pulses("glitch", 0, 0, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_pulses("post_glitch", 1, 0, 0);
    check("post_glitch_data", 32'(received_data), 32'h1C);

    // Reset in the middle of a frame.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    resetn = 1'b0;
    wait_clk(5);
    check("midrst_data", 32'(received_data), 32'h00);
    check("midrst_pulses", {29'd0, received_data_en, parity_err, frame_err}, 32'd0);
    resetn = 1'b1;
    // Rest of the aborted frame: only high bits, so no false start bit.
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_clk(TMO + 100);
    check_pulses("midrst", 0, 0, 0);
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    check_pulses("fE0", 1, 0, 0);
    check("fE0_data", 32'(received_data), 32'hE0);

    check("one_hot", 32'(multi_cnt), 32'd0);
    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal clk samples required to accept a new ps2_clk level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles allowed between falling edges inside a frame (1 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1: system clock, 50 MHz.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk, input, 1: raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_dat, input, 1: raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port received_data, output, 8: last valid scan-code byte, held until the next valid frame.
REQ-008 SHALL have port received_data_en, output, 1: one-cycle pulse marking a new valid byte on received_data.
REQ-009 SHALL have port parity_err, output, 1: one-cycle pulse on an odd-parity failure.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit or an inter-bit timeout.

Function
REQ-011 SHALL synchronise ps2_clk and ps2_dat through two flip-flops each before any use.
REQ-012 SHALL drive a filtered clock level that changes only after FILTER_LEN consecutive identical synchronised samples; filtered level resets to 1.
REQ-013 SHALL generate a single-cycle fall event on each 1->0 transition of the filtered clock, sampling synchronised ps2_dat in that same cycle.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: fall with dat=0 -> DATA, bit counter=0, parity accumulator=0; fall with dat=1 -> stay IDLE, no output.
REQ-016 DATA: each fall shifts dat in LSB-first and XORs it into the parity accumulator; after the 8th bit -> PARITY.
REQ-017 PARITY: on a fall, store dat as the parity bit -> STOP.
REQ-018 STOP, on a fall: if dat=0 -> pulse frame_err; else if the 8 data bits plus the parity bit hold an even count of ones -> pulse parity_err; else load received_data and pulse received_data_en; in all cases -> IDLE.
REQ-019 SHALL assert received_data_en, parity_err or frame_err exactly in the cycle after the stop-bit fall event, each for exactly one cycle.
REQ-020 SHALL assert at most one of received_data_en, parity_err, frame_err in any cycle.
REQ-021 SHALL leave received_data unchanged on parity_err or frame_err.
REQ-022 SHALL count cycles since the last fall while not in IDLE; on reaching TIMEOUT_CYCLES, SHALL pulse frame_err next cycle and return to IDLE.
REQ-023 A fall event in the same cycle as timeout expiry SHALL take priority: the bit is accepted and the counter cleared, with no frame_err.
REQ-024 The timeout counter SHALL saturate (no wrap), be cleared on every fall, and be held at 0 in IDLE.
REQ-025 SHALL treat each byte independently; prefix bytes (0xF0, 0xE0) are delivered as ordinary bytes.

Reset
REQ-026 SHALL, while resetn=0, force: state IDLE; received_data=0x00; received_data_en=0; parity_err=0; frame_err=0; counters 0; shift register 0; synchroniser and filtered clock 1.
REQ-027 SHALL abort any partial frame on reset with no output pulse; after release, reception SHALL restart only at the next start bit.

Verification
REQ-028 Frame 0x1D, parity 1, stop 1, 10 kHz ps2_clk -> received_data=0x1D, one-cycle received_data_en, no errors.
REQ-029 Back-to-back 0xF0 (parity 1) then 0x1C (parity 0) -> two en pulses, received_data 0xF0 then 0x1C.
REQ-030 Frame 0x29 sent with parity 1 (wrong) -> parity_err pulse only, received_data keeps its previous value.
REQ-031 Frame 0x5A, parity 1, stop 0 -> frame_err pulse only, no en.
REQ-032 Start bit plus 4 data bits, then 50000 quiet cycles -> frame_err, state IDLE; next clean 0x76 frame (parity 0) -> received_data=0x76.
REQ-033 A 3-cycle low glitch on ps2_clk in IDLE -> no fall event and no outputs; resetn pulled low mid-frame -> no pulse, outputs 0.
